// File: rtl/atten_ramp_ctrl.sv
// Attenuation-stage runtime controller: accepts gain-change commands, ramps a Q15 gain
// toward the target in sample-paced steps, and applies the gain to a 16-bit sample stream.
module atten_ramp_ctrl #(
  parameter logic [15:0] GAIN_RESET = 16'd32767,
  parameter int unsigned DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [15:0]      cfg_target,
  input  logic [15:0]      cfg_step,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic [15:0]      gain_cur,
  output logic             busy,
  output logic             done
);

  localparam logic [15:0] GAIN_MAX = 16'd32767;

  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t           state_q;
  logic [15:0]      gain_q;
  logic [15:0]      target_q;
  logic [15:0]      step_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             cfg_ready_q;
  logic             busy_q;
  logic             done_q;
  logic             out_valid_q;
  logic [15:0]      out_data_q;

  logic [15:0]        tgt_c;
  logic [16:0]        up_sum_c;
  logic [16:0]        dn_gap_c;
  logic [15:0]        gain_d;
  logic signed [31:0] prod_c;

  // Next ramp gain in 17-bit unsigned, clamped so it never overshoots the target
  always_comb begin
    tgt_c    = (cfg_target > GAIN_MAX) ? GAIN_MAX : cfg_target;
    up_sum_c = {1'b0, gain_q} + {1'b0, step_q};
    dn_gap_c = {1'b0, gain_q} - {1'b0, target_q};
    gain_d   = gain_q;
    if (target_q > gain_q) begin
      gain_d = (up_sum_c >= {1'b0, target_q}) ? target_q : up_sum_c[15:0];
    end else begin
      gain_d = ({1'b0, step_q} >= dn_gap_c) ? target_q : (gain_q - step_q);
    end
  end

  // Gain is zero-extended so it multiplies as a non-negative signed operand
  assign prod_c = 32'($signed(in_data)) * 32'($signed({1'b0, gain_q}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gain_q      <= GAIN_RESET;
      target_q    <= GAIN_RESET;
      step_q      <= 16'd0;
      div_q       <= '0;
      cnt_q       <= '0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_data_q <= 16'(prod_c >>> 15);
      end
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_valid) begin
            target_q    <= tgt_c;
            step_q      <= cfg_step;
            div_q       <= cfg_div;
            cnt_q       <= '0;
            cfg_ready_q <= 1'b0;
            if ((tgt_c == gain_q) || (cfg_step == 16'd0)) begin
              gain_q  <= tgt_c;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= RAMP;
            end
          end
        end
        RAMP: begin
          // Paced by accepted samples only; gain holds while in_valid is low
          if (in_valid) begin
            if (cnt_q == div_q) begin
              cnt_q  <= '0;
              gain_q <= gain_d;
              if (gain_d == target_q) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
        end
        DONE: begin
          cfg_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          cfg_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign gain_cur  = gain_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_atten_ramp_ctrl.sv
// Scoreboard bench for atten_ramp_ctrl: directed commands and sample streams with
// hand-computed gain schedules; a negedge monitor pops expected samples as they emerge.
module tb_atten_ramp_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_target;
  logic [15:0] cfg_step;
  logic [15:0] cfg_div;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic [15:0] out_data;
  logic [15:0] gain_cur;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rwb     = 0;
  int exp_q[$];
  int gtab[$];
  logic [15:0] dtab[$];
  int done_log[$];
  int acc_log[$];

  atten_ramp_ctrl #(.GAIN_RESET(16'd32767), .DIV_W(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_target(cfg_target), .cfg_step(cfg_step), .cfg_div(cfg_div),
    .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data),
    .gain_cur(gain_cur), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model(input logic [15:0] d, input int g);
    logic signed [31:0] p;
    logic signed [15:0] r;
    p = 32'($signed(d)) * 32'(g);
    r = 16'(p >>> 15);
    return int'(r);
  endfunction

  // Output monitor: every presented sample must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 1, 0);
      end else begin
        check("out_data", int'($signed(out_data)), exp_q.pop_front());
      end
    end
  end

  // Handshake / done event log by cycle number
  always @(posedge clk) begin
    if (!rst) begin
      if (cfg_valid && cfg_ready) acc_log.push_back(cyc);
      if (done) done_log.push_back(cyc);
      if (busy && cfg_ready) rwb <= rwb + 1;
    end
    cyc <= cyc + 1;
  end

  task automatic sample(input logic [15:0] d, input int e);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Sample k uses gtab[k/per]; gap idle cycles precede each sample
  task automatic run_stream(input int nsamp, input int gap, input int per);
    int idx;
    int g;
    for (int k = 0; k < nsamp; k++) begin
      idx = k / per;
      if (idx >= gtab.size()) idx = gtab.size() - 1;
      g = gtab[idx];
      for (int j = 0; j < gap; j++) begin
        in_valid = 1'b0;
        check("gain_hold", int'(gain_cur), g);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = dtab[k % dtab.size()];
      check("gain_cur", int'(gain_cur), g);
      exp_q.push_back(model(in_data, g));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_cfg(input logic [15:0] t, input logic [15:0] s, input logic [15:0] d);
    int n;
    cfg_target = t;
    cfg_step   = s;
    cfg_div    = d;
    cfg_valid  = 1'b1;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cfg_ready) check("cfg_ready_timeout", 0, 1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int na;
    int r0;
    int n;
    rst = 1'b1; cfg_valid = 1'b0; cfg_target = 16'd0; cfg_step = 16'd0; cfg_div = 16'd0;
    in_valid = 1'b0; in_data = 16'd0;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_gain", int'(gain_cur), 32767);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Passthrough at reset gain: floor of x*32767/32768
    sample(16'h8000, -32767);
    sample(16'd1000, 999);
    sample(16'hFC18, -1000);
    sample(16'h7FFF, 32766);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_out_valid", int'(out_valid), 0);

    // Reset asserted mid-stream clears outputs immediately
    sample(16'd2000, 1999);
    in_data = 16'd3000;
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_gain", int'(gain_cur), 32767);
    check("midrst_cfg_ready", int'(cfg_ready), 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp down, step every 4 samples
    send_cfg(16'd16384, 16'd4096, 16'd3);
    check("ramp_busy", int'(busy), 1);
    check("ramp_cfg_ready", int'(cfg_ready), 0);
    nd = done_log.size();
    r0 = rwb;
    gtab = '{32767, 28671, 24575, 20479, 16384};
    dtab = '{16'h4000, 16'hC000, 16'h7FFF, 16'h0001};
    run_stream(20, 0, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ramp_done_pulses", done_log.size() - nd, 1);
    check("ramp_ready_while_busy", rwb - r0, 0);
    check("ramp_final_gain", int'(gain_cur), 16384);
    check("ramp_end_ready", int'(cfg_ready), 1);
    check("ramp_end_busy", int'(busy), 0);

    // Immediate jump, then equal target
    send_cfg(16'd8192, 16'd0, 16'd0);
    check("jump_gain", int'(gain_cur), 8192);
    check("jump_done", int'(done), 1);
    check("jump_ready", int'(cfg_ready), 0);
    @(posedge clk); #1;
    check("jump_done_clear", int'(done), 0);
    check("jump_ready_back", int'(cfg_ready), 1);
    send_cfg(16'd8192, 16'd100, 16'd5);
    check("equal_done", int'(done), 1);
    check("equal_gain", int'(gain_cur), 8192);
    check("equal_busy", int'(busy), 0);
    @(posedge clk); #1;
    sample(16'h8000, -8192);
    in_valid = 1'b0;

    // Ramp up with gapped samples, div=0
    send_cfg(16'd0, 16'd0, 16'd0);
    send_cfg(16'd32767, 16'd10000, 16'd0);
    gtab = '{0, 10000, 20000, 30000, 32767};
    dtab = '{16'd12345, 16'hD000, 16'd20000};
    run_stream(6, 2, 1);
    check("up_final_gain", int'(gain_cur), 32767);

    // Command held during ramp is accepted the cycle after done
    send_cfg(16'd0, 16'd8192, 16'd0);
    na = acc_log.size();
    nd = done_log.size();
    cfg_target = 16'hFFFF;
    cfg_step   = 16'd0;
    cfg_div    = 16'd0;
    cfg_valid  = 1'b1;
    gtab = '{32767, 24575, 16383, 8191};
    dtab = '{16'h7FFF, 16'h8001};
    run_stream(4, 0, 1);
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_accepted", int'(acc_log.size() > na), 1);
    check("bp_done_seen", int'(done_log.size() > nd), 1);
    if (acc_log.size() > na && done_log.size() > nd)
      check("bp_accept_after_done", acc_log[na] - done_log[nd], 1);
    check("bp_clamped_gain", int'(gain_cur), 32767);

    // Reset in the middle of a slow ramp, then a fresh command
    send_cfg(16'd0, 16'd1, 16'd0);
    gtab = '{32767, 32766, 32765};
    dtab = '{16'd16384};
    run_stream(3, 0, 1);
    check("slow_ramp_busy", int'(busy), 1);
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("rampRst_gain", int'(gain_cur), 32767);
    check("rampRst_busy", int'(busy), 0);
    check("rampRst_ready", int'(cfg_ready), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_cfg(16'd100, 16'd0, 16'd0);
    check("post_rst_gain", int'(gain_cur), 100);
    check("post_rst_done", int'(done), 1);

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
